amplitude_window_detector: RTL



---
 rtl/amplitude_window_detector_pkg.sv | 21 ++
 rtl/amplitude_window_detector_min_max.sv | 52 +++++
 rtl/amplitude_window_detector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/amplitude_window_detector_pkg.sv
// Shared types and helpers for the amplitude window detector: FSM state encoding,
// default widths and the widened signed difference used for peak-to-peak.
package amplitude_window_detector_pkg;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_WIDTH  = 17;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Callers sign-extend into 64 bits and cast the result down to DATA_WIDTH+1,
    // where the difference of two DATA_WIDTH signed values always fits.
    function automatic logic signed [63:0] signed_diff(input logic signed [63:0] a,
                                                       input logic signed [63:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/amplitude_window_detector_min_max.sv
// Running signed max/min registers; load seeds both from one sample, clear discards them.
// next_max/next_min expose the post-update values so the final sample of a window can be reported.
module min_max_tracker
    import amplitude_window_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         valid,
    output logic signed [DATA_WIDTH-1:0] running_max,
    output logic signed [DATA_WIDTH-1:0] running_min,
    output logic signed [DATA_WIDTH-1:0] next_max,
    output logic signed [DATA_WIDTH-1:0] next_min
);

    logic signed [DATA_WIDTH-1:0] max_q, min_q;

    always_comb begin
        next_max = max_q;
        next_min = min_q;
        if (clear) begin
            next_max = '0;
            next_min = '0;
        end else if (valid) begin
            if (load) begin
                next_max = sample;
                next_min = sample;
            end else begin
                if (sample > max_q) next_max = sample;
                if (sample < min_q) next_min = sample;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= next_max;
            min_q <= next_min;
        end
    end

    assign running_max = max_q;
    assign running_min = min_q;

endmodule

// File: rtl/amplitude_window_detector.sv
// Windowed signed max/min/peak-to-peak of a sample stream; result strobes one cycle after the last
// window sample is accepted, no backpressure. AMPLITUDE_WINDOW_DETECTOR_THRESHOLD_EN adds a p2p threshold flag.
module amplitude_window_detector
    import amplitude_window_detector_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int WINDOW_LENGTH = 400,
    parameter int SETTLE_LENGTH = 64,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data,
    input  logic                         data_valid,
    input  logic                         restart,
`ifdef AMPLITUDE_WINDOW_DETECTOR_THRESHOLD_EN
    input  logic        [DATA_WIDTH:0]   threshold,
    output logic                         above_threshold,
`endif
    output logic signed [DATA_WIDTH-1:0] maximum,
    output logic signed [DATA_WIDTH-1:0] minimum,
    output logic        [DATA_WIDTH:0]   peak_to_peak,
    output logic                         measurement_valid,
    output logic                         busy
);

    if (WINDOW_LENGTH < 2 || SETTLE_LENGTH < 0 ||
        WINDOW_LENGTH >= (1 << COUNT_WIDTH) || SETTLE_LENGTH >= (1 << COUNT_WIDTH)) begin : g_param_check
        $error("amplitude_window_detector: WINDOW_LENGTH/SETTLE_LENGTH out of range for COUNT_WIDTH");
    end

    localparam state_e START_STATE = (SETTLE_LENGTH == 0) ? MEASURE : SETTLE;
    localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST =
        COUNT_WIDTH'((SETTLE_LENGTH > 0) ? SETTLE_LENGTH - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0] WINDOW_LAST = COUNT_WIDTH'(WINDOW_LENGTH - 1);

    state_e                       state_q, state_d;
    logic [COUNT_WIDTH-1:0]       count_q, count_d;
    logic                         trk_clear, trk_load, trk_valid, report;
    logic signed [DATA_WIDTH-1:0] run_max, run_min, next_max, next_min;
    logic signed [DATA_WIDTH-1:0] maximum_q, minimum_q;
    logic        [DATA_WIDTH:0]   p2p_q, p2p_d;
    logic                         meas_vld_q, busy_q;

    min_max_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .clear       (trk_clear),
        .load        (trk_load),
        .sample      (data),
        .valid       (trk_valid),
        .running_max (run_max),
        .running_min (run_min),
        .next_max    (next_max),
        .next_min    (next_min)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        trk_clear = 1'b0;
        trk_load  = 1'b0;
        trk_valid = 1'b0;
        report    = 1'b0;
        if (restart) begin
            state_d   = START_STATE;
            count_d   = '0;
            trk_clear = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (data_valid) begin
                        if (count_q == SETTLE_LAST) begin
                            state_d = MEASURE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + COUNT_WIDTH'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (data_valid) begin
                        trk_valid = 1'b1;
                        trk_load  = (count_q == '0);
                        if (count_q == WINDOW_LAST) begin
                            state_d = REPORT;
                            report  = 1'b1;
                            count_d = '0;
                        end else begin
                            count_d = count_q + COUNT_WIDTH'(1);
                        end
                    end
                end
                REPORT: begin
                    // A sample arriving while the result is presented opens the next window.
                    state_d = MEASURE;
                    count_d = '0;
                    if (data_valid) begin
                        trk_valid = 1'b1;
                        trk_load  = 1'b1;
                        count_d   = COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = START_STATE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign p2p_d = (DATA_WIDTH+1)'(signed_diff(64'(next_max), 64'(next_min)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= START_STATE;
            count_q    <= '0;
            maximum_q  <= '0;
            minimum_q  <= '0;
            p2p_q      <= '0;
            meas_vld_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            meas_vld_q <= report;
            busy_q     <= (state_d != REPORT);
            if (report) begin
                maximum_q <= next_max;
                minimum_q <= next_min;
                p2p_q     <= p2p_d;
            end
        end
    end

`ifdef AMPLITUDE_WINDOW_DETECTOR_THRESHOLD_EN
    logic above_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            above_q <= 1'b0;
        end else if (report) begin
            above_q <= (p2p_d >= threshold);
        end
    end

    assign above_threshold = above_q;
`endif

    assign maximum           = maximum_q;
    assign minimum           = minimum_q;
    assign peak_to_peak      = p2p_q;
    assign measurement_valid = meas_vld_q;
    assign busy              = busy_q;

    // Running values are only consumed through next_max/next_min.
    logic unused_run;
    assign unused_run = ^{run_max, run_min};

endmodule
